inst_fetch_arbiter: RTL

Sequences every access to the single-port, combinational-read instruction ROM. It runs a prefetching PC with a FIFO_DEPTH-entry instruction/PC queue feeding the IF stage, and handles branch redirect and flush. It also shares the ROM read port with a debug/loader read requester under alternating-priority arbitration. The block sits between the IF stage and the instruction ROM and drives the ROM's ce/addr.

---
 rtl/inst_fetch_arbiter_if.sv | 37 +++
 rtl/inst_fetch_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_arbiter_if.sv
// rtl/inst_fetch_arbiter_if.sv - ROM, IF-stage, redirect and debug read signals of the fetch arbiter
interface inst_fetch_arbiter_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        br_flag;
    logic [31:0] br_target;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_valid;
    logic [31:0] dbg_data;

    modport master (
        output rom_ce, rom_addr,
        input  rom_data,
        output if_valid, if_inst, if_pc,
        input  if_ready,
        input  br_flag, br_target,
        input  dbg_req, dbg_addr,
        output dbg_gnt, dbg_valid, dbg_data
    );

    modport slave (
        input  rom_ce, rom_addr,
        output rom_data,
        input  if_valid, if_inst, if_pc,
        output if_ready,
        output br_flag, br_target,
        output dbg_req, dbg_addr,
        input  dbg_gnt, dbg_valid, dbg_data
    );
endinterface

// File: rtl/inst_fetch_arbiter.sv
// rtl/inst_fetch_arbiter.sv - prefetching instruction queue sharing the ROM read port with a debug reader
// Optional INST_DBG_PORT_EN enables debug read arbitration; otherwise debug outputs are tied low.
module inst_fetch_arbiter #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    inst_fetch_arbiter_if.master bus
);
    localparam int               PTR_W        = $clog2(FIFO_DEPTH);
    localparam int               CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic             ROMCE_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FETCH = 2'd1,
        SLOT_DBG   = 2'd2
    } slot_t;

    slot_t            last_gnt;
    slot_t            last_gnt_next;
    slot_t            slot;
    logic             fetch_want;
    logic             dbg_want;
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      inst_mem [FIFO_DEPTH];
    logic [31:0]      pc_mem   [FIFO_DEPTH];
    logic             empty;
    logic             push;
    logic             pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= SLOT_FETCH;
        end else begin
            last_gnt <= last_gnt_next;
        end
    end

    // A full queue never fetches, even when the head is popped this cycle.
    always_comb begin
        slot          = SLOT_IDLE;
        last_gnt_next = last_gnt;
        fetch_want    = rst && (count < DEPTH_CNT) && !bus.br_flag;
`ifdef INST_DBG_PORT_EN
        dbg_want      = rst && bus.dbg_req;
`else
        dbg_want      = 1'b0;
`endif
        if (fetch_want && dbg_want) begin
            slot = (last_gnt == SLOT_DBG) ? SLOT_FETCH : SLOT_DBG;
        end else if (fetch_want) begin
            slot = SLOT_FETCH;
        end else if (dbg_want) begin
            slot = SLOT_DBG;
        end
        if (slot != SLOT_IDLE) begin
            last_gnt_next = slot;
        end
    end

    always_comb begin
        bus.rom_ce   = ~ROMCE_ENABLE;
        bus.rom_addr = 32'h0;
        case (slot)
            SLOT_FETCH: begin
                bus.rom_ce   = ROMCE_ENABLE;
                bus.rom_addr = fetch_pc;
            end
            SLOT_DBG: begin
                bus.rom_ce   = ROMCE_ENABLE;
                bus.rom_addr = bus.dbg_addr;
            end
            default: begin
                bus.rom_ce   = ~ROMCE_ENABLE;
                bus.rom_addr = 32'h0;
            end
        endcase
    end

    assign empty        = (count == '0);
    assign push         = (slot == SLOT_FETCH);
    assign pop          = bus.if_valid && bus.if_ready;
    assign bus.if_valid = !empty && !bus.br_flag;
    assign bus.if_inst  = empty ? 32'h0 : inst_mem[rd_ptr];
    assign bus.if_pc    = empty ? 32'h0 : pc_mem[rd_ptr];

    // A redirect flushes everything and voids any pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.br_flag) begin
            fetch_pc <= bus.br_target & ~32'h3;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.rom_data;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

`ifdef INST_DBG_PORT_EN
    logic        dbg_valid_q;
    logic [31:0] dbg_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= 32'h0;
        end else begin
            dbg_valid_q <= (slot == SLOT_DBG);
            if (slot == SLOT_DBG) begin
                dbg_data_q <= bus.rom_data;
            end
        end
    end

    assign bus.dbg_gnt   = (slot == SLOT_DBG);
    assign bus.dbg_valid = dbg_valid_q;
    assign bus.dbg_data  = dbg_data_q;
`else
    logic unused_dbg;
    assign unused_dbg    = bus.dbg_req;
    assign bus.dbg_gnt   = 1'b0;
    assign bus.dbg_valid = 1'b0;
    assign bus.dbg_data  = 32'h0;
`endif
endmodule
